// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline controller.
//   seq_state_e : sequencer FSM state. The 3-bit encoding is visible on the debug port.
//   run_evt_e   : highest-priority event seen in a cycle where the pipeline could advance.
//   NOP_INSTR   : instruction word loaded into IF/ID when it is annulled.
//   REG_ZERO    : hard-wired zero register, which never creates a hazard.
package pipeline_pkg;

  typedef enum logic [2:0] {
    StInit      = 3'd0,
    StRun       = 3'd1,
    StLoadStall = 3'd2,
    StMemWait   = 3'd3,
    StHalt      = 3'd4,
    StErr       = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    EvNone,
    EvMemWait,
    EvHalt,
    EvLoadUse
  } run_evt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // State that follows a cycle in which the pipeline could have advanced.
  function automatic seq_state_e evt_next_state(run_evt_e evt);
    seq_state_e nxt;
    unique case (evt)
      EvMemWait: nxt = StMemWait;
      EvHalt:    nxt = StHalt;
      EvLoadUse: nxt = StLoadStall;
      default:   nxt = StRun;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle between the pipeline sequencer and the datapath it controls.
//   Hazard and status inputs (datapath -> sequencer):
//     id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt,
//     branch_taken, branch_annul, mem_req, mem_ready, halt_req
//   Control outputs (sequencer -> datapath):
//     le_pc, le_npc, le_ifid, ifid_annul, idex_bubble, stall_all, mem_err, state
// The master modport is the sequencer. The slave modport is the datapath side.
interface pipeline_sequencer_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       branch_taken;
  logic       branch_annul;
  logic       mem_req;
  logic       mem_ready;
  logic       halt_req;

  logic       le_pc;
  logic       le_npc;
  logic       le_ifid;
  logic       ifid_annul;
  logic       idex_bubble;
  logic       stall_all;
  logic       mem_err;
  logic [2:0] state;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt,
    input  branch_taken, branch_annul, mem_req, mem_ready, halt_req,
    output le_pc, le_npc, le_ifid, ifid_annul, idex_bubble, stall_all, mem_err, state
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt,
    output branch_taken, branch_annul, mem_req, mem_ready, halt_req,
    input  le_pc, le_npc, le_ifid, ifid_annul, idex_bubble, stall_all, mem_err, state
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   id_rs_i/id_rt_i          : source registers of the instruction in ID
//   id_use_rs_i/id_use_rt_i  : the ID instruction actually reads rs/rt
//   ex_mem_read_i            : the instruction in EX is a load
//   ex_rt_i                  : destination register of that load
//   hazard_o                 : ID needs the load result before it is available
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  output logic       hazard_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_use_rs_i && (id_rs_i == ex_rt_i);
  assign rt_hit   = id_use_rt_i && (id_rt_i == ex_rt_i);
  assign hazard_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller. It drives the PC/nPC/IF-ID load enables, the IF/ID annul
// signal, ID/EX bubble insertion and the global stall. The sources are start-up
// sequencing, load-use hazards, taken-branch annulment, memory waits and halt requests.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   seq_io        : hazard/status inputs and control outputs (see pipeline_sequencer_if)
// All outputs are combinational from the state and the current inputs.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 2,   // 1..15
  parameter int unsigned MEM_TIMEOUT = 64   // 2..255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pipeline_sequencer_if.master  seq_io
);

  localparam logic [3:0] StartupLoad = 4'(STARTUP_CYC - 1);
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  seq_state_e state_q, state_d;
  logic [3:0] startup_q, startup_d;
  logic [7:0] tmo_q, tmo_d;
  logic       mem_err_q, mem_err_d;

  logic       hazard;
  run_evt_e   run_evt;

  logic       le_all;
  logic       annul;
  logic       bubble;
  logic       stall;

  load_use_detect u_load_use_detect (
    .id_rs_i       (seq_io.id_rs),
    .id_rt_i       (seq_io.id_rt),
    .id_use_rs_i   (seq_io.id_use_rs),
    .id_use_rt_i   (seq_io.id_use_rt),
    .ex_mem_read_i (seq_io.ex_mem_read),
    .ex_rt_i       (seq_io.ex_rt),
    .hazard_o      (hazard)
  );

  // Highest-priority event in a cycle where the pipeline could advance. During
  // LOAD_STALL the EX stage holds the bubble, so a second load-use detection would be false.
  always_comb begin
    run_evt = EvNone;
    if (seq_io.mem_req && !seq_io.mem_ready) begin
      run_evt = EvMemWait;
    end else if (seq_io.halt_req) begin
      run_evt = EvHalt;
    end else if (hazard && (state_q != StLoadStall)) begin
      run_evt = EvLoadUse;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StInit;
      startup_q <= StartupLoad;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      startup_q <= startup_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    startup_d = startup_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StInit: begin
        if (startup_q == 4'd0) begin
          state_d = StRun;
        end else begin
          startup_d = startup_q - 4'd1;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      StMemWait: begin
        if (!seq_io.mem_ready) begin
          if (tmo_q == TimeoutLast) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end else begin
          // The access completes this cycle, so the pipeline advances as in RUN.
          state_d = evt_next_state(run_evt);
          if (run_evt == EvMemWait) begin
            tmo_d = '0;
          end
        end
      end
      default: begin
        // RUN, LOAD_STALL and HALT all resolve through the run decision. A HALT cycle
        // whose request has dropped is an ordinary advancing cycle.
        state_d = evt_next_state(run_evt);
        if (run_evt == EvMemWait) begin
          tmo_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    le_all = 1'b0;
    annul  = 1'b0;
    bubble = 1'b0;
    stall  = 1'b0;
    unique case (state_q)
      StInit: begin
        annul = 1'b1;
      end
      StErr: begin
        stall = 1'b1;
      end
      default: begin
        if ((state_q == StMemWait) && !seq_io.mem_ready) begin
          stall = 1'b1;
        end else begin
          unique case (run_evt)
            EvMemWait, EvHalt: stall = 1'b1;
            EvLoadUse:         bubble = 1'b1;
            default: begin
              le_all = 1'b1;
              annul  = seq_io.branch_taken && seq_io.branch_annul;
            end
          endcase
        end
      end
    endcase
  end

  assign seq_io.le_pc       = le_all;
  assign seq_io.le_npc      = le_all;
  assign seq_io.le_ifid     = le_all;
  assign seq_io.ifid_annul  = annul;
  assign seq_io.idex_bubble = bubble;
  assign seq_io.stall_all   = stall;
  assign seq_io.mem_err     = mem_err_q;
  assign seq_io.state       = state_q;

endmodule
